// File: rtl/genius_game_fsm.sv
// Genius (Simon) game-control core: grows a pseudo-random colour sequence,
// plays it back one lamp at a time and checks the player's presses.
// Optional build macro: GENIUS_INPUT_TIMEOUT_EN adds a WAIT_IN input timeout.
module genius_game_fsm #(
  parameter int unsigned MAX_LEN   = 32,
  parameter int unsigned TICKS_ON  = 25000000,
  parameter int unsigned TICKS_OFF = 12500000,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
`ifdef GENIUS_INPUT_TIMEOUT_EN
  , parameter int unsigned TICKS_TIMEOUT = 150000000
`endif
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       start,
  input  logic       btn_valid,
  input  logic [1:0] btn_color,
  output logic       lamp_en,
  output logic [1:0] lamp_color,
  output logic [5:0] level,
  output logic [2:0] state_out,
  output logic       game_over,
  output logic       win
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ADD      = 3'd1,
    SHOW_ON  = 3'd2,
    SHOW_OFF = 3'd3,
    WAIT_IN  = 3'd4,
    ECHO_ON  = 3'd5,
    LOSE     = 3'd6,
    WIN      = 3'd7
  } state_t;

  // Index width is just wide enough to address MAX_LEN entries.
  localparam int unsigned IDX_W     = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [31:0] ON_LAST   = 32'(TICKS_ON - 1);
  localparam logic [31:0] OFF_LAST  = 32'(TICKS_OFF - 1);
  localparam logic [5:0]  MAX_LEN_6 = 6'(MAX_LEN);
`ifdef GENIUS_INPUT_TIMEOUT_EN
  localparam logic [31:0] TIMEOUT_LAST = 32'(TICKS_TIMEOUT - 1);
`endif

  state_t      state_q, state_d;
  logic [5:0]  len_q, len_d;
  logic [5:0]  idx_q, idx_d;
  logic [31:0] timer_q, timer_d;
  logic [15:0] lfsr_q, lfsr_d;
  logic [1:0]  echo_q, echo_d;
  logic [1:0]  seq_q [MAX_LEN];
  logic        seq_we_s;
  logic        last_idx_s;
  logic [1:0]  seq_rd_s;

  assign seq_rd_s   = seq_q[idx_q[IDX_W-1:0]];
  assign last_idx_s = (idx_q == (len_q - 6'd1));
  // Fibonacci LFSR, taps x^16 + x^14 + x^13 + x^11 + 1.
  assign lfsr_d     = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

  // State, counters, LFSR and echo-colour registers with synchronous reset.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q <= IDLE;
      len_q   <= 6'd0;
      idx_q   <= 6'd0;
      timer_q <= 32'd0;
      lfsr_q  <= LFSR_SEED;
      echo_q  <= 2'd0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      timer_q <= timer_d;
      lfsr_q  <= lfsr_d;
      echo_q  <= echo_d;
    end
  end

  // Sequence storage: ADD appends the current LFSR low bits at position len.
  always_ff @(posedge CLOCK_50) begin
    if (seq_we_s && !reset) begin
      seq_q[len_q[IDX_W-1:0]] <= lfsr_q[1:0];
    end
  end

  // Next-state logic; every transition clears the timer.
  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    idx_d    = idx_q;
    timer_d  = timer_q + 32'd1;
    echo_d   = echo_q;
    seq_we_s = 1'b0;
    case (state_q)
      IDLE, LOSE, WIN: begin
        timer_d = 32'd0;
        if (start) begin
          state_d = ADD;
          len_d   = 6'd0;
        end else begin
          state_d = state_q;
        end
      end
      ADD: begin
        seq_we_s = 1'b1;
        len_d    = len_q + 6'd1;
        idx_d    = 6'd0;
        timer_d  = 32'd0;
        state_d  = SHOW_ON;
      end
      SHOW_ON: begin
        if (timer_q == ON_LAST) begin
          state_d = SHOW_OFF;
          timer_d = 32'd0;
        end else begin
          state_d = SHOW_ON;
        end
      end
      SHOW_OFF: begin
        if (timer_q == OFF_LAST) begin
          timer_d = 32'd0;
          if (last_idx_s) begin
            state_d = WAIT_IN;
            idx_d   = 6'd0;
          end else begin
            state_d = SHOW_ON;
            idx_d   = idx_q + 6'd1;
          end
        end else begin
          state_d = SHOW_OFF;
        end
      end
      WAIT_IN: begin
        if (btn_valid) begin
          timer_d = 32'd0;
          if (btn_color == seq_rd_s) begin
            state_d = ECHO_ON;
            echo_d  = btn_color;
          end else begin
            state_d = LOSE;
          end
        end
`ifdef GENIUS_INPUT_TIMEOUT_EN
        else if (timer_q == TIMEOUT_LAST) begin
          state_d = LOSE;
          timer_d = 32'd0;
        end else begin
          state_d = WAIT_IN;
        end
`else
        else begin
          timer_d = 32'd0;
        end
`endif
      end
      ECHO_ON: begin
        if (timer_q == OFF_LAST) begin
          timer_d = 32'd0;
          if (last_idx_s && (len_q == MAX_LEN_6)) begin
            state_d = WIN;
          end else if (last_idx_s) begin
            state_d = ADD;
          end else begin
            state_d = WAIT_IN;
            idx_d   = idx_q + 6'd1;
          end
        end else begin
          state_d = ECHO_ON;
        end
      end
      default: begin
        state_d = IDLE;
        timer_d = 32'd0;
      end
    endcase
  end

  // Output decode from the registered state, index and stored sequence.
  always_comb begin
    lamp_en    = 1'b0;
    lamp_color = 2'd0;
    level      = len_q;
    state_out  = 3'(state_q);
    game_over  = 1'b0;
    win        = 1'b0;
    case (state_q)
      SHOW_ON: begin
        lamp_en    = 1'b1;
        lamp_color = seq_rd_s;
      end
      ECHO_ON: begin
        lamp_en    = 1'b1;
        lamp_color = echo_q;
      end
      LOSE:    game_over = 1'b1;
      WIN:     win       = 1'b1;
      default: lamp_en   = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_genius_game_fsm.sv
// Directed self-checking bench for genius_game_fsm with
// MAX_LEN=3, TICKS_ON=4, TICKS_OFF=2, TICKS_TIMEOUT=10.
module tb_genius_game_fsm;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       btn_valid;
  logic [1:0] btn_color;
  logic       lamp_en;
  logic [1:0] lamp_color;
  logic [5:0] level;
  logic [2:0] state_out;
  logic       game_over;
  logic       win;

  int         total = 0;
  int         bad   = 0;
  logic [15:0] lfsr_m;
  logic [1:0]  exp_seq [3];
  logic [1:0]  wrong_c;

  genius_game_fsm #(
    .MAX_LEN   (3),
    .TICKS_ON  (4),
    .TICKS_OFF (2),
    .LFSR_SEED (16'hACE1)
`ifdef GENIUS_INPUT_TIMEOUT_EN
    , .TICKS_TIMEOUT (10)
`endif
  ) dut (
    .CLOCK_50   (clk),
    .reset      (reset),
    .start      (start),
    .btn_valid  (btn_valid),
    .btn_color  (btn_color),
    .lamp_en    (lamp_en),
    .lamp_color (lamp_color),
    .level      (level),
    .state_out  (state_out),
    .game_over  (game_over),
    .win        (win)
  );

  always #5 clk = ~clk;

  // Reference LFSR: x^16+x^14+x^13+x^11+1, seeded on reset, shifting every cycle.
  always @(posedge clk) begin
    if (reset) lfsr_m <= 16'hACE1;
    else       lfsr_m <= {lfsr_m[14:0], lfsr_m[15] ^ lfsr_m[13] ^ lfsr_m[12] ^ lfsr_m[10]};
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called in the ADD cycle: check it, record the colour being appended, step on.
  task automatic add_step(input int len_before);
    chk("add_state", 32'(state_out), 32'd1);
    chk("add_level", 32'(level), 32'(len_before));
    chk("add_lamp", 32'(lamp_en), 32'd0);
    exp_seq[len_before] = lfsr_m[1:0];
    tick();
  endtask

  // Called in the first SHOW_ON cycle; ends in the first WAIT_IN cycle.
  // With noise set, stray presses are injected during SHOW_ON and on the
  // last SHOW_OFF cycle, all of which must be ignored.
  task automatic play_round(input int n, input bit noise);
    for (int k = 0; k < n; k++) begin
      for (int t = 0; t < 4; t++) begin
        chk("show_state", 32'(state_out), 32'd2);
        chk("show_lamp", 32'(lamp_en), 32'd1);
        chk("show_color", 32'(lamp_color), 32'(exp_seq[k]));
        chk("show_level", 32'(level), 32'(n));
        if (noise && t == 1) begin
          btn_valid = 1'b1;
          btn_color = exp_seq[k] ^ 2'd1;
        end
        tick();
        btn_valid = 1'b0;
      end
      for (int t = 0; t < 2; t++) begin
        chk("gap_state", 32'(state_out), 32'd3);
        chk("gap_lamp", 32'(lamp_en), 32'd0);
        chk("gap_color", 32'(lamp_color), 32'd0);
        if (noise && t == 1 && k == n - 1) begin
          btn_valid = 1'b1;
          btn_color = exp_seq[0] ^ 2'd2;
        end
        tick();
        btn_valid = 1'b0;
      end
    end
    chk("wait_state", 32'(state_out), 32'd4);
    chk("wait_lamp", 32'(lamp_en), 32'd0);
  endtask

  // Correct press from WAIT_IN: echo for exactly 2 cycles.
  task automatic press_ok(input logic [1:0] c);
    btn_valid = 1'b1;
    btn_color = c;
    tick();
    btn_valid = 1'b0;
    for (int t = 0; t < 2; t++) begin
      chk("echo_state", 32'(state_out), 32'd5);
      chk("echo_lamp", 32'(lamp_en), 32'd1);
      chk("echo_color", 32'(lamp_color), 32'(c));
      tick();
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    reset     = 1'b1;
    start     = 1'b0;
    btn_valid = 1'b0;
    btn_color = 2'd0;

    // 1. Reset for 3 cycles, then idle without start.
    repeat (3) tick();
    reset = 1'b0;
    chk("rst_lamp", 32'(lamp_en), 32'd0);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_state", 32'(state_out), 32'd0);
    chk("rst_over", 32'(game_over), 32'd0);
    chk("rst_win", 32'(win), 32'd0);
    repeat (5) tick();
    chk("idle_hold", 32'(state_out), 32'd0);

    // 2. Start: ADD, one 4-cycle lamp, 2-cycle gap, WAIT_IN (stray presses ignored).
    pulse_start();
    add_step(0);
    play_round(1, 1'b1);

    // 3. Correct press, echo, then a two-lamp playback.
    press_ok(exp_seq[0]);
    add_step(1);
    play_round(2, 1'b0);

    // 4. Wrong press loses; restart from LOSE.
    wrong_c   = exp_seq[0] ^ 2'd1;
    btn_valid = 1'b1;
    btn_color = wrong_c;
    tick();
    btn_valid = 1'b0;
    chk("lose_state", 32'(state_out), 32'd6);
    chk("lose_over", 32'(game_over), 32'd1);
    chk("lose_lamp", 32'(lamp_en), 32'd0);
    btn_valid = 1'b1;
    btn_color = exp_seq[0];
    tick();
    btn_valid = 1'b0;
    chk("lose_hold", 32'(state_out), 32'd6);
    pulse_start();
    chk("restart_over", 32'(game_over), 32'd0);
    add_step(0);
    chk("restart_level", 32'(level), 32'd1);

    // 5. Full game to WIN; start during WAIT_IN is ignored.
    play_round(1, 1'b0);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("start_ignored", 32'(state_out), 32'd4);
    press_ok(exp_seq[0]);
    add_step(1);
    play_round(2, 1'b0);
    press_ok(exp_seq[0]);
    chk("mid_round_wait", 32'(state_out), 32'd4);
    press_ok(exp_seq[1]);
    add_step(2);
    play_round(3, 1'b1);
    press_ok(exp_seq[0]);
    press_ok(exp_seq[1]);
    press_ok(exp_seq[2]);
    chk("win_state", 32'(state_out), 32'd7);
    chk("win_flag", 32'(win), 32'd1);
    chk("win_level", 32'(level), 32'd3);
    chk("win_lamp", 32'(lamp_en), 32'd0);

    // Restart from WIN, then reset in the middle of SHOW_ON.
    pulse_start();
    chk("win_restart", 32'(win), 32'd0);
    add_step(0);
    chk("mid_show", 32'(lamp_en), 32'd1);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mid_rst_state", 32'(state_out), 32'd0);
    chk("mid_rst_lamp", 32'(lamp_en), 32'd0);
    chk("mid_rst_level", 32'(level), 32'd0);

    // 6. No press in WAIT_IN.
    pulse_start();
    add_step(0);
    play_round(1, 1'b0);
`ifdef GENIUS_INPUT_TIMEOUT_EN
    for (int i = 1; i < 10; i++) begin
      tick();
      chk("to_wait", 32'(state_out), 32'd4);
    end
    tick();
    chk("to_state", 32'(state_out), 32'd6);
    chk("to_over", 32'(game_over), 32'd1);
`else
    repeat (100) tick();
    chk("no_timeout", 32'(state_out), 32'd4);
    chk("no_timeout_over", 32'(game_over), 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
